// File: rtl/ss_adc_conv_ctrl.sv
// Single-slope ADC conversion controller: ramp sequencing, shared count,
// per-pixel comparator sync and one-shot capture strobes.
//
// state    | meaning
// IDLE     | waiting for start, ramp parked
// RAMP_RST | ramp generator held in reset for RESET_CYCLES cycles
// CONVERT  | ramp running, count advancing, first trips strobe enable
// DONE     | one-cycle end-of-conversion pulse, count holds COUNT_MAX
`timescale 1ns/1ps
module ss_adc_conv_ctrl #(
    parameter int NUM_PIXELS   = 1,
    parameter int COUNT_MAX    = 255,
    parameter int RESET_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [NUM_PIXELS-1:0] comp_in,
    output logic [NUM_PIXELS-1:0] enable,
    output logic [7:0]            count,
    output logic                  ramp_rst,
    output logic                  ramp_en,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_PIXELS-1:0] overflow
);

    localparam int              RW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RW-1:0]   RST_LOAD = RW'(RESET_CYCLES - 1);
    localparam logic [7:0]      CMAX     = 8'(COUNT_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAMP_RST = 2'd1,
        CONVERT  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [RW-1:0]         rst_cnt;
    logic [NUM_PIXELS-1:0] sync_q1;
    logic [NUM_PIXELS-1:0] comp_s;
    logic [NUM_PIXELS-1:0] tripped;
    logic                  start_ok;
    logic                  at_max;

    assign start_ok = (state == IDLE) && start;
    assign at_max   = (count == CMAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = RAMP_RST;
            RAMP_RST: if (rst_cnt == '0) state_nxt = CONVERT;
            CONVERT:  if (at_max) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // At full scale every still-untripped pixel is strobed so the bank
    // captures COUNT_MAX for it.
    always_comb begin
        ramp_rst = (state == RAMP_RST);
        ramp_en  = (state == CONVERT);
        busy     = (state != IDLE);
        done     = (state == DONE);
        enable   = '0;
        if (state == CONVERT) begin
            if (at_max) begin
                enable = ~tripped;
            end else begin
                enable = comp_s & ~tripped;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1  <= '0;
            comp_s   <= '0;
            rst_cnt  <= '0;
            count    <= '0;
            tripped  <= '0;
            overflow <= '0;
        end else begin
            sync_q1 <= comp_in;
            comp_s  <= sync_q1;

            if (start_ok) begin
                rst_cnt <= RST_LOAD;
            end else if ((state == RAMP_RST) && (rst_cnt != '0)) begin
                rst_cnt <= rst_cnt - 1'b1;
            end

            if ((state == CONVERT) && !at_max) begin
                count <= count + 8'd1;
            end else if (state == DONE) begin
                count <= '0;
            end

            if (start_ok) begin
                tripped  <= '0;
                overflow <= '0;
            end else if (state == CONVERT) begin
                tripped <= tripped | enable;
                // A pixel whose comparator is genuinely high at full scale is a real trip.
                if (at_max) begin
                    overflow <= ~tripped & ~comp_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_ss_adc_conv_ctrl.sv
// Scoreboard bench for ss_adc_conv_ctrl: expected strobes and end-of-conversion
// overflow are queued by the stimulus and matched by a negedge monitor.
`timescale 1ns/1ps
module tb_ss_adc_conv_ctrl;

    localparam int NP = 4;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          start   = 1'b0;
    logic [NP-1:0] comp_in = '0;
    logic [NP-1:0] enable;
    logic [7:0]    count;
    logic          ramp_rst;
    logic          ramp_en;
    logic          busy;
    logic          done;
    logic [NP-1:0] overflow;

    int n_pass   = 0;
    int n_checks = 0;

    // {kind, mask, count}: kind 0 = enable strobe, kind 1 = done with overflow mask
    logic [12:0] exp_q[$];

    ss_adc_conv_ctrl #(
        .NUM_PIXELS  (NP),
        .COUNT_MAX   (255),
        .RESET_CYCLES(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .comp_in (comp_in),
        .enable  (enable),
        .count   (count),
        .ramp_rst(ramp_rst),
        .ramp_en (ramp_en),
        .busy    (busy),
        .done    (done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic note_timeout(input string name);
        n_checks++;
        $display("FAIL %s: actual timeout required event", name);
    endtask

    task automatic push_en(input logic [NP-1:0] mask, input int cnt);
        exp_q.push_back({1'b0, mask, 8'(cnt)});
    endtask

    task automatic push_done(input logic [NP-1:0] ovf);
        exp_q.push_back({1'b1, ovf, 8'd255});
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (enable != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_enable", {19'd0, 1'b0, enable, count}, 32'd0);
                end else begin
                    check("enable_event", {19'd0, 1'b0, enable, count}, {19'd0, exp_q.pop_front()});
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {19'd0, 1'b1, overflow, count}, 32'd0);
                end else begin
                    check("done_event", {19'd0, 1'b1, overflow, count}, {19'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_count(input int cnt, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (ramp_en && count == 8'(cnt)) ok = 1'b1;
        end
    endtask

    // Drives comp_in two cycles early so the synchronised value lands at cnt.
    task automatic set_at(input int pix, input int cnt, input logic val);
        bit ok;
        wait_count(cnt - 2, ok);
        if (!ok) note_timeout("stim_wait");
        else comp_in[pix] = val;
    endtask

    task automatic run_conv();
        int n_rst  = 0;
        int n_en   = 0;
        int n_done = 0;
        int bad    = 0;
        bit fin    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int c = 0; c < 1000 && !fin; c++) begin
            if (ramp_rst) n_rst++;
            if (ramp_en) begin
                if (count != 8'(n_en)) bad++;
                n_en++;
            end
            if (done) n_done++;
            if (!busy) fin = 1'b1;
            else @(negedge clk);
        end
        if (!fin) note_timeout("conv_end");
        check("ramp_rst_cycles", n_rst, 4);
        check("convert_cycles", n_en, 256);
        check("count_sequence_errs", bad, 0);
        check("done_pulses", n_done, 1);
        check("count_idle", {24'd0, count}, 32'd0);
    endtask

    task automatic settle();
        comp_in = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bit ok;
        #2 reset_n = 1'b0;
        #1;
        check("rst_count", {24'd0, count}, 32'd0);
        check("rst_ctrl", {28'd0, ramp_rst, ramp_en, busy, done}, 32'd0);
        check("rst_enable_ovf", {24'd0, enable, overflow}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // All comparators quiet: every pixel forced to full scale.
        push_en(4'b1111, 255);
        push_done(4'b1111);
        run_conv();
        settle();

        // Pixel 1 high before ramp, 0 at 10, 2 at 100, 3 overflows.
        comp_in = 4'b0010;
        repeat (3) @(negedge clk);
        push_en(4'b0010, 0);
        push_en(4'b0001, 10);
        push_en(4'b0100, 100);
        push_en(4'b1000, 255);
        push_done(4'b1000);
        fork
            run_conv();
            set_at(0, 10, 1'b1);
            set_at(2, 100, 1'b1);
        join
        settle();

        // Glitchy pixel 0 strobes once at its first synced assertion.
        push_en(4'b0001, 50);
        push_en(4'b1110, 255);
        push_done(4'b1110);
        fork
            run_conv();
            begin
                set_at(0, 50, 1'b1);
                set_at(0, 53, 1'b0);
                set_at(0, 57, 1'b1);
                set_at(0, 60, 1'b0);
            end
        join
        settle();

        // Pixels 0 and 3 trip together.
        push_en(4'b1001, 77);
        push_en(4'b0110, 255);
        push_done(4'b0110);
        fork
            run_conv();
            begin
                set_at(0, 77, 1'b1);
                comp_in[3] = 1'b1;
            end
        join
        settle();

        // Start while busy and start in DONE are both ignored.
        push_en(4'b1111, 255);
        push_done(4'b1111);
        fork
            run_conv();
            begin
                wait_count(30, ok);
                if (!ok) note_timeout("start30_wait");
                else begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            begin
                ok = 1'b0;
                for (int c = 0; c < 2000 && !ok; c++) begin
                    @(negedge clk);
                    if (done) ok = 1'b1;
                end
                if (!ok) note_timeout("done_wait");
                else begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        for (int c = 0; c < 5; c++) begin
            check("no_restart_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        settle();

        // Reset mid-conversion, then no strobes until a fresh start.
        comp_in = 4'b0010;
        repeat (3) @(negedge clk);
        push_en(4'b0010, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_count(120, ok);
        if (!ok) note_timeout("count120_wait");
        check("pre_reset_ramp_en", {31'd0, ramp_en}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_count", {24'd0, count}, 32'd0);
        check("mid_rst_ctrl", {28'd0, ramp_rst, ramp_en, busy, done}, 32'd0);
        check("mid_rst_enable_ovf", {24'd0, enable, overflow}, 32'd0);
        check("queue_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        push_en(4'b0010, 0);
        push_en(4'b0100, 100);
        push_en(4'b1001, 255);
        push_done(4'b1001);
        fork
            run_conv();
            set_at(2, 100, 1'b1);
        join
        settle();

        check("queue_empty_end", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
